// File: rtl/seg14_pkg.sv
// Shared definitions for the 14-segment display bus: glyph font, ASCII codes,
// sequencer states and default bus geometry.
package seg14_pkg;

    localparam int DIGITS_DEF = 12;
    localparam int SEGW_DEF   = 14;
    localparam int CHARW_DEF  = 8;

    localparam logic [CHARW_DEF-1:0] CH_SPACE   = 8'h20;
    localparam logic [CHARW_DEF-1:0] CH_UNKNOWN = 8'h3F;

    typedef enum logic {
        ST_UNSYNCED = 1'b0,
        ST_COLLECT  = 1'b1
    } seq_state_t;

    // Segment order, bit 13 down to bit 0: a b c d e f g1 g2 h i j k l m
    localparam logic [SEGW_DEF-1:0] GLYPH_BLANK = 14'b00000000000000;
    localparam logic [SEGW_DEF-1:0] GLYPH_A = 14'b11101111000000;
    localparam logic [SEGW_DEF-1:0] GLYPH_B = 14'b11110001010010;
    localparam logic [SEGW_DEF-1:0] GLYPH_C = 14'b10011100000000;
    localparam logic [SEGW_DEF-1:0] GLYPH_D = 14'b11110000010010;
    localparam logic [SEGW_DEF-1:0] GLYPH_E = 14'b10011110000000;
    localparam logic [SEGW_DEF-1:0] GLYPH_F = 14'b10001110000000;
    localparam logic [SEGW_DEF-1:0] GLYPH_G = 14'b10111101000000;
    localparam logic [SEGW_DEF-1:0] GLYPH_H = 14'b01101111000000;
    localparam logic [SEGW_DEF-1:0] GLYPH_I = 14'b10010000010010;
    localparam logic [SEGW_DEF-1:0] GLYPH_J = 14'b01111000000000;
    localparam logic [SEGW_DEF-1:0] GLYPH_K = 14'b00001110001100;
    localparam logic [SEGW_DEF-1:0] GLYPH_L = 14'b00011100000000;
    localparam logic [SEGW_DEF-1:0] GLYPH_M = 14'b01101100101000;
    localparam logic [SEGW_DEF-1:0] GLYPH_N = 14'b01101100100100;
    localparam logic [SEGW_DEF-1:0] GLYPH_O = 14'b11111100000000;
    localparam logic [SEGW_DEF-1:0] GLYPH_P = 14'b11001111000000;
    localparam logic [SEGW_DEF-1:0] GLYPH_Q = 14'b11111100000100;
    localparam logic [SEGW_DEF-1:0] GLYPH_R = 14'b11001111000100;
    localparam logic [SEGW_DEF-1:0] GLYPH_S = 14'b10110111000000;
    localparam logic [SEGW_DEF-1:0] GLYPH_T = 14'b10000000010010;
    localparam logic [SEGW_DEF-1:0] GLYPH_U = 14'b01111100000000;
    localparam logic [SEGW_DEF-1:0] GLYPH_V = 14'b00001100001001;
    localparam logic [SEGW_DEF-1:0] GLYPH_W = 14'b01101100000101;
    localparam logic [SEGW_DEF-1:0] GLYPH_X = 14'b00000000101101;
    localparam logic [SEGW_DEF-1:0] GLYPH_Y = 14'b00000000101010;
    localparam logic [SEGW_DEF-1:0] GLYPH_Z = 14'b10010000001001;
    localparam logic [SEGW_DEF-1:0] GLYPH_0 = 14'b11111100001001;
    localparam logic [SEGW_DEF-1:0] GLYPH_1 = 14'b01100000001000;
    localparam logic [SEGW_DEF-1:0] GLYPH_2 = 14'b11011011000000;
    localparam logic [SEGW_DEF-1:0] GLYPH_3 = 14'b11110001000000;
    localparam logic [SEGW_DEF-1:0] GLYPH_4 = 14'b01100111000000;
    localparam logic [SEGW_DEF-1:0] GLYPH_5 = GLYPH_S;
    localparam logic [SEGW_DEF-1:0] GLYPH_6 = 14'b10111111000000;
    localparam logic [SEGW_DEF-1:0] GLYPH_7 = 14'b11100000000000;
    localparam logic [SEGW_DEF-1:0] GLYPH_8 = 14'b11111111000000;
    localparam logic [SEGW_DEF-1:0] GLYPH_9 = 14'b11110111000000;

    // Decode table; '5' is absent because it reads back as 'S'.
    localparam int FONT_N = 35;

    localparam logic [SEGW_DEF-1:0] FONT_PAT [FONT_N] = '{
        GLYPH_A, GLYPH_B, GLYPH_C, GLYPH_D, GLYPH_E, GLYPH_F, GLYPH_G,
        GLYPH_H, GLYPH_I, GLYPH_J, GLYPH_K, GLYPH_L, GLYPH_M, GLYPH_N,
        GLYPH_O, GLYPH_P, GLYPH_Q, GLYPH_R, GLYPH_S, GLYPH_T, GLYPH_U,
        GLYPH_V, GLYPH_W, GLYPH_X, GLYPH_Y, GLYPH_Z,
        GLYPH_0, GLYPH_1, GLYPH_2, GLYPH_3, GLYPH_4,
        GLYPH_6, GLYPH_7, GLYPH_8, GLYPH_9
    };

    localparam logic [CHARW_DEF-1:0] FONT_CHR [FONT_N] = '{
        8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47,
        8'h48, 8'h49, 8'h4A, 8'h4B, 8'h4C, 8'h4D, 8'h4E,
        8'h4F, 8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55,
        8'h56, 8'h57, 8'h58, 8'h59, 8'h5A,
        8'h30, 8'h31, 8'h32, 8'h33, 8'h34,
        8'h36, 8'h37, 8'h38, 8'h39
    };

endpackage

// File: rtl/seg14_glyph_lut.sv
// Combinational 14-segment pattern to ASCII lookup with an unknown-glyph flag.
module seg14_glyph_lut
    import seg14_pkg::*;
(
    input  logic [SEGW_DEF-1:0]  pattern,
    output logic [CHARW_DEF-1:0] ascii,
    output logic                 err
);

    // Scan from the top of the table down so the lowest-index (letter) entry wins.
    always_comb begin
        ascii = CH_UNKNOWN;
        err   = 1'b1;
        if (pattern == GLYPH_BLANK) begin
            ascii = CH_SPACE;
            err   = 1'b0;
        end
        for (int i = FONT_N - 1; i >= 0; i--) begin
            if (pattern == FONT_PAT[i]) begin
                ascii = FONT_CHR[i];
                err   = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg14_scan_decoder.sv
// Passive readback of the multiplexed 14-segment bus: samples digit select and
// pattern, decodes glyphs, reassembles 12-digit frames and hands them out on a
// valid/ready port.
//
//   state        | meaning
//   -------------+-----------------------------------------------------------
//   ST_UNSYNCED  | waiting for digit 0; buffer kept but never emitted
//   ST_COLLECT   | digits 0..expected-1 captured, expected_q is next index
module seg14_scan_decoder
    import seg14_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEF,
    parameter int SEGW   = SEGW_DEF,
    parameter int CHARW  = CHARW_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DIGITS-1:0]       sel_in,
    input  logic [SEGW-1:0]         segm_in,
    output logic [DIGITS*CHARW-1:0] frame_data,
    output logic                    frame_glyph_err,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic                    sel_err,
    output logic                    frame_drop
);

    localparam int IDXW = $clog2(DIGITS);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

    logic [DIGITS-1:0]       sel_q;
    logic [SEGW-1:0]         segm_q;
    seq_state_t              state_q, state_d;
    logic [IDXW-1:0]         expected_q, expected_d;
    logic [CHARW-1:0]        buf_q [DIGITS-1];
    logic [CHARW-1:0]        buf_d [DIGITS-1];
    logic [DIGITS-2:0]       gerr_q, gerr_d;
    logic [DIGITS*CHARW-1:0] frame_data_q, frame_data_d;
    logic                    frame_valid_q, frame_valid_d;
    logic                    frame_glyph_err_q, frame_glyph_err_d;
    logic                    sel_err_q, sel_err_d;
    logic                    frame_drop_q, frame_drop_d;

    logic                    sel_multi, sel_onehot;
    logic [IDXW-1:0]         sel_idx;
    logic [CHARW-1:0]        glyph_ch;
    logic                    glyph_err;
    logic                    wr_en, complete, load;
    logic [DIGITS*CHARW-1:0] frame_nxt;

    seg14_glyph_lut u_lut (
        .pattern (segm_q),
        .ascii   (glyph_ch),
        .err     (glyph_err)
    );

    // Classify the registered select and find the one-hot position.
    always_comb begin
        sel_multi  = |(sel_q & (sel_q - DIGITS'(1)));
        sel_onehot = (sel_q != '0) && !sel_multi;
        sel_idx    = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (sel_q[i]) sel_idx = IDXW'(i);
        end
    end

    // Sequencer and digit buffer next state.
    always_comb begin
        state_d    = state_q;
        expected_d = expected_q;
        buf_d      = buf_q;
        gerr_d     = gerr_q;
        sel_err_d  = 1'b0;
        complete   = 1'b0;
        wr_en      = 1'b0;
        if (sel_multi) begin
            sel_err_d  = 1'b1;
            state_d    = ST_UNSYNCED;
            expected_d = '0;
        end else if (sel_onehot) begin
            if (sel_idx == '0) begin
                wr_en      = 1'b1;
                gerr_d     = '0;
                state_d    = ST_COLLECT;
                expected_d = IDXW'(1);
            end else if (state_q == ST_COLLECT && sel_idx == expected_q && sel_idx == LAST_IDX) begin
                complete   = 1'b1;
                state_d    = ST_UNSYNCED;
                expected_d = '0;
            end else if (state_q == ST_COLLECT && sel_idx == expected_q) begin
                wr_en      = 1'b1;
                expected_d = expected_q + IDXW'(1);
            end else if (state_q == ST_COLLECT && sel_idx == expected_q - IDXW'(1)) begin
                // Driver is still dwelling on the previous digit: take the newer pattern.
                wr_en = 1'b1;
            end else begin
                state_d    = ST_UNSYNCED;
                expected_d = '0;
            end
        end
        if (wr_en) begin
            for (int i = 0; i < DIGITS - 1; i++) begin
                if (sel_idx == IDXW'(i)) begin
                    buf_d[i]  = glyph_ch;
                    gerr_d[i] = glyph_err;
                end
            end
        end
    end

    // Completed frame is the last digit straight from the LUT on top of the buffer.
    always_comb begin
        frame_nxt = '0;
        for (int i = 0; i < DIGITS - 1; i++) begin
            frame_nxt[i*CHARW +: CHARW] = buf_q[i];
        end
        frame_nxt[(DIGITS-1)*CHARW +: CHARW] = glyph_ch;
    end

    // Output register: load when empty or draining this cycle, otherwise drop.
    always_comb begin
        load              = complete && (!frame_valid_q || frame_ready);
        frame_drop_d      = complete && !load;
        frame_data_d      = frame_data_q;
        frame_glyph_err_d = frame_glyph_err_q;
        frame_valid_d     = frame_valid_q;
        if (load) begin
            frame_data_d      = frame_nxt;
            frame_glyph_err_d = (|gerr_q) | glyph_err;
            frame_valid_d     = 1'b1;
        end else if (frame_valid_q && frame_ready) begin
            frame_valid_d = 1'b0;
        end
    end

    // All state, including the input sampling stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q             <= '0;
            segm_q            <= '0;
            state_q           <= ST_UNSYNCED;
            expected_q        <= '0;
            for (int i = 0; i < DIGITS - 1; i++) buf_q[i] <= CH_SPACE;
            gerr_q            <= '0;
            frame_data_q      <= '0;
            frame_valid_q     <= 1'b0;
            frame_glyph_err_q <= 1'b0;
            sel_err_q         <= 1'b0;
            frame_drop_q      <= 1'b0;
        end else begin
            sel_q             <= sel_in;
            segm_q            <= segm_in;
            state_q           <= state_d;
            expected_q        <= expected_d;
            buf_q             <= buf_d;
            gerr_q            <= gerr_d;
            frame_data_q      <= frame_data_d;
            frame_valid_q     <= frame_valid_d;
            frame_glyph_err_q <= frame_glyph_err_d;
            sel_err_q         <= sel_err_d;
            frame_drop_q      <= frame_drop_d;
        end
    end

    assign frame_data      = frame_data_q;
    assign frame_valid     = frame_valid_q;
    assign frame_glyph_err = frame_glyph_err_q;
    assign sel_err         = sel_err_q;
    assign frame_drop      = frame_drop_q;

endmodule

// File: doc/seg14_scan_decoder.md
# seg14_scan_decoder

Passive receiver for the multiplexed 14-segment display bus: it samples the one-hot digit select and segment pattern each clock, decodes every pattern back to an ASCII character, and reassembles the 12 digits into a frame. Complete, in-order frames go out through a valid/ready handshake. It sits beside, or in place of, the physical display, and is used for on-chip self-check and readback of the display driver's output.

## Interface
- DIGITS, 12: digits per frame; `sel` width.
- SEGW, 14: segment pattern width.
- CHARW, 8: decoded character width (ASCII).
- clk  in  1: sole clock, rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- sel_in  in  DIGITS: one-hot digit select from the display driver; bit k selects digit k.
- segm_in  in  SEGW: segment pattern for the selected digit; bit 13 = segment a.
- frame_data  out  DIGITS*CHARW: decoded frame; digit k occupies bits [8k+7:8k].
- frame_glyph_err  out  1: at least one digit in `frame_data` failed to decode.
- frame_valid  out  1: `frame_data` is valid.
- frame_ready  in  1: consumer accepts the frame.
- sel_err  out  1: one-cycle pulse when `sel` has more than one bit set.
- frame_drop  out  1: one-cycle pulse when a completed frame is discarded.

## Operation
- Stage 1: register `sel_in` and `segm_in` into `sel_q` and `segm_q` every cycle.
- Stage 2: classify `sel_q`.
  - `sel_q` == 0: idle cycle; no write, sequencer unchanged.
  - `sel_q` with popcount > 1: pulse `sel_err`, no write, `expected` := 0, `synced` := 0.
  - `sel_q` one-hot: index k = bit position. Decode `segm_q` with the glyph LUT.
- Glyph LUT:
  - Exact 14-bit match gives the ASCII code. Required codes: 0 → 0x20, C 10011100000000 → 0x43, E 10011110000000 → 0x45, I 10010000010010 → 0x49, L 00011100000000 → 0x4C, N 01101100100100 → 0x4E, O 11111100000000 → 0x4F, P 11001111000000 → 0x50.
  - The LUT also covers the rest of the team font (A–Z, 0–9).
  - Where a letter and a digit share a pattern (S/5), the letter wins.
  - No match gives 0x3F ('?') and sets a per-slot glyph-error bit.
- Sequencer state, one of:
  - UNSYNCED: waiting for digit 0.
  - COLLECT: `expected` = next index.
- Transitions:
  - k == 0 always: write slot 0, `expected` := 1, enter COLLECT, clear all slot error bits except slot 0's new one.
  - COLLECT, k == `expected`: write slot k, `expected`++.
  - COLLECT, k == `expected`−1 (digit held): overwrite slot k; `expected` unchanged; no error.
  - Any other k: silently enter UNSYNCED; the buffer is kept but not emitted.
- Frame completion: in COLLECT, k == DIGITS−1 == `expected`.
  - The frame is {new char, buffer slots 10..0}.
  - `frame_glyph_err` is the OR of all slot error bits including the new one.
  - Then `expected` := 0 and the state becomes UNSYNCED; the next frame needs digit 0.
- Output register:
  - Loads on completion if `frame_valid` == 0 or (`frame_valid` & `frame_ready`) in the same cycle.
  - Otherwise the new frame is discarded and `frame_drop` pulses.
  - `frame_valid` clears on `frame_valid` & `frame_ready` with no simultaneous load.
  - `frame_data` is stable while `frame_valid` & !`frame_ready`.
- Reset (any time, including mid-frame):
  - `frame_data` = 0, `frame_valid` = 0, `frame_glyph_err` = 0, `sel_err` = 0, `frame_drop` = 0.
  - `sel_q` = 0, `segm_q` = 0.
  - Buffer slots = 0x20, error bits = 0, state UNSYNCED, `expected` = 0.

## Timing
- `sel_err` pulses, and buffer writes happen, at edge N+1 when the offending/selected input is present before edge N.
- Last digit present before edge N → `frame_valid` high after edge N+1. Latency is 2 clocks.
- With the driver cycling 0..11 and `frame_ready` = 1, one frame is produced every 12 clocks.
- `frame_ready` may be held high permanently. Transfer happens on any edge with `frame_valid` & `frame_ready`.

## Structure
- Package `seg14_pkg` holds:
  - the 14-bit glyph constants, shared with the display driver;
  - ASCII constants CH_SPACE and CH_UNKNOWN (0x3F);
  - the UNSYNCED/COLLECT state enum;
  - the DIGITS/SEGW/CHARW defaults.
- Sub-module `seg14_glyph_lut`: purely combinational pattern → {ascii, err} lookup, reusable by other readback blocks.
- Everything else (input stage, one-hot check, sequencer, buffer, output register) lives in `seg14_scan_decoder`.

## Test plan
- Reset, then cycle the driver through E,L,␠,O,N,E,␠,P,I,E,C,E on digits 0–11 with `frame_ready` = 1 → `frame_valid` 2 clocks after digit 11; `frame_data` bytes 0..11 = 45 4C 20 4F 4E 45 20 50 49 45 43 45; `frame_glyph_err` = 0; a new frame every 12 clocks.
- `frame_ready` = 0 for 30 clocks → first frame stays stable; `frame_drop` pulses once per later completion; raising `frame_ready` transfers the original frame.
- `sel_in` = 12'b000000000011 mid-frame → `sel_err` one-cycle pulse; no frame until a full 0..11 pass starting at digit 0.
- `segm_in` = 14'h3FFF on digit 4 → byte 4 = 0x3F, `frame_glyph_err` = 1; the next clean frame has `frame_glyph_err` = 0.
- Release reset while the driver is at digit 5 → no frame until digit 0 followed by 1..11. Assert `rst_n` at digit 7 → all outputs 0 immediately (asynchronously); the next frame needs a fresh digit 0.
- Hold digit 3 for 3 cycles with a changing pattern (O then N) → no error; frame byte 3 = last value (0x4E).
